// File: rtl/insn_fetch_if.sv
// Fetch-side bus bundle: memory request/response handshake, byte stream to the decoder, redirect.
// With INSN_FETCH_BYTE_ADDR_EN defined the bundle also carries o_byte_addr.
interface insn_fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] o_mem_address;
  logic [DATA_WIDTH-1:0]    o_mem_data;
  logic                     o_mem_cmd;
  logic                     o_mem_valid;
  logic                     i_mem_ready;
  logic [DATA_WIDTH-1:0]    i_mem_data;
  logic                     i_mem_res_valid;
  logic                     o_mem_res_ready;
  logic [7:0]               o_byte;
  logic                     o_byte_valid;
  logic                     i_byte_ready;
  logic                     i_redirect;
  logic [ADDRESS_WIDTH-1:0] i_redirect_addr;
`ifdef INSN_FETCH_BYTE_ADDR_EN
  logic [ADDRESS_WIDTH-1:0] o_byte_addr;
`endif

  modport master (
`ifdef INSN_FETCH_BYTE_ADDR_EN
    output o_byte_addr,
`endif
    output o_mem_address, o_mem_data, o_mem_cmd, o_mem_valid, o_mem_res_ready,
    output o_byte, o_byte_valid,
    input  i_mem_ready, i_mem_data, i_mem_res_valid, i_byte_ready,
    input  i_redirect, i_redirect_addr
  );

  modport slave (
`ifdef INSN_FETCH_BYTE_ADDR_EN
    input  o_byte_addr,
`endif
    input  o_mem_address, o_mem_data, o_mem_cmd, o_mem_valid, o_mem_res_ready,
    input  o_byte, o_byte_valid,
    output i_mem_ready, i_mem_data, i_mem_res_valid, i_byte_ready,
    output i_redirect, i_redirect_addr
  );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: aligned word reads, little-endian unpack into a byte FIFO, byte stream out.
// Optional INSN_FETCH_BYTE_ADDR_EN adds o_byte_addr tracking the address of the head byte.
module insn_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       FIFO_BYTES    = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic         clk,
  input  logic         reset,
  insn_fetch_if.master bus
);
  localparam int WB = DATA_WIDTH / 8;
  localparam int SW = (WB > 1) ? $clog2(WB) : 1;
  localparam int PW = $clog2(FIFO_BYTES);
  localparam int CW = PW + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'(WB - 1);
  localparam logic MEM_CMD_READ = 1'b0;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                   state, state_nx;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [SW-1:0]            skip;
  logic [7:0]               fifo [FIFO_BYTES];
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count, free, n_push;
  logic                     req_valid, res_ready, push, pop, byte_valid;

  assign free       = CW'(FIFO_BYTES) - count;
  assign n_push     = CW'(WB) - CW'(skip);
  assign byte_valid = (count != '0) && !reset;
  assign pop        = byte_valid && bus.i_byte_ready && !bus.i_redirect;

  always_comb begin
    state_nx  = state;
    req_valid = 1'b0;
    res_ready = 1'b0;
    push      = 1'b0;
    case (state)
      S_REQ: begin
        // space for a whole word is reserved at issue, so the response is never back-pressured
        req_valid = (free >= CW'(WB));
        if (req_valid && bus.i_mem_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        res_ready = 1'b1;
        if (bus.i_mem_res_valid) begin
          push     = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_DRAIN: begin
        res_ready = 1'b1;
        if (bus.i_mem_res_valid) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
    if (bus.i_redirect) begin
      push = 1'b0;
      // a request still owed a response must have it swallowed before fetching anew
      if ((state == S_REQ && req_valid && bus.i_mem_ready) ||
          (state != S_REQ && !bus.i_mem_res_valid))
        state_nx = S_DRAIN;
      else
        state_nx = S_REQ;
    end
    if (reset) begin
      req_valid = 1'b0;
      res_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      fetch_addr <= RESET_PC & ~LOW_MASK;
      skip       <= SW'(RESET_PC & LOW_MASK);
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_nx;
      if (bus.i_redirect) begin
        fetch_addr <= bus.i_redirect_addr & ~LOW_MASK;
        skip       <= SW'(bus.i_redirect_addr & LOW_MASK);
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
      end else begin
        if (push) begin
          fetch_addr <= fetch_addr + ADDRESS_WIDTH'(WB);
          skip       <= '0;
          wr_ptr     <= wr_ptr + PW'(n_push);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (push ? n_push : '0) - (pop ? CW'(1) : '0);
      end
    end
  end

  // byte k of the word lands at wr_ptr + (k - skip); leading bytes below skip are dropped
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int k = 0; k < WB; k++) begin
        if (k >= int'(skip))
          fifo[wr_ptr + PW'(k) - PW'(skip)] <= bus.i_mem_data[8*k +: 8];
      end
    end
  end

  assign bus.o_mem_address   = fetch_addr;
  assign bus.o_mem_data      = '0;
  assign bus.o_mem_cmd       = MEM_CMD_READ;
  assign bus.o_mem_valid     = req_valid;
  assign bus.o_mem_res_ready = res_ready;
  assign bus.o_byte_valid    = byte_valid;
  assign bus.o_byte          = byte_valid ? fifo[rd_ptr] : 8'h00;

`ifdef INSN_FETCH_BYTE_ADDR_EN
  logic [ADDRESS_WIDTH-1:0] byte_addr;
  always_ff @(posedge clk) begin
    if (reset)               byte_addr <= RESET_PC;
    else if (bus.i_redirect) byte_addr <= bus.i_redirect_addr;
    else if (pop)            byte_addr <= byte_addr + 1'b1;
  end
  assign bus.o_byte_addr = byte_addr;
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: memory responder plus a byte-stream model (each popped byte must be
// the memory byte at the next expected address, restarted at every redirect/reset).
module tb_insn_fetch;
  localparam int AW = 32, DW = 32, FB = 16;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  insn_fetch_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  insn_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_BYTES(FB), .RESET_PC(RESET_PC))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int p_ready = 100, p_bready = 100, lat_min = 0, lat_max = 0, redir_when = 0;
  logic [31:0] redir_addr, exp_addr = RESET_PC, pend_addr;
  int pend = 0, pend_dly = 0;
  bit post_redir = 0, redir_fired = 0, rst_req = 1;
  logic [31:0] req_q [$], pop_q [$], ba_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] req;
    logic [7:0]  b0, b1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] qat(input logic [31:0] q [$], input int i);
    if (i < q.size()) return 64'(q[i]);
    return 'x;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] b);
    case (b)
      32'h100: return 8'hAA;
      32'h101: return 8'hBB;
      32'h102: return 8'hCC;
      32'h103: return 8'hDD;
      default: return (b[7:0] + 8'd1) ^ b[15:8];
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  // one clock: drive at negedge, settle, account for every handshake that fires at the next posedge
  task automatic step();
    int  pend0;
    bit  fire;
    @(negedge clk);
    if (post_redir && !rst_req) chk("byte_valid_after_redirect", bus.o_byte_valid, 0);
    post_redir = 0;
    reset = rst_req;
    if (rst_req) begin
      bus.i_mem_ready = 0; bus.i_mem_res_valid = 0; bus.i_byte_ready = 0;
      bus.i_redirect = 0; bus.i_mem_data = '0; bus.i_redirect_addr = '0;
      pend = 0; exp_addr = RESET_PC; redir_when = 0;
      req_q.delete(); pop_q.delete(); ba_q.delete();
      #1;
      chk("rst_mem_valid", bus.o_mem_valid, 0);
      chk("rst_res_ready", bus.o_mem_res_ready, 0);
      chk("rst_byte_valid", bus.o_byte_valid, 0);
      return;
    end
    pend0 = pend;
    bus.i_mem_ready = ($urandom_range(99) < p_ready);
    if (pend > 0 && pend_dly == 0) begin
      bus.i_mem_res_valid = 1; bus.i_mem_data = mem_word(pend_addr);
    end else begin
      bus.i_mem_res_valid = 0; bus.i_mem_data = $urandom;
    end
    bus.i_byte_ready = ($urandom_range(99) < p_bready);
    bus.i_redirect = 0; bus.i_redirect_addr = $urandom;
    #1;
    fire = (redir_when == 1) ||
           (redir_when == 2 && bus.o_mem_valid && bus.i_mem_ready) ||
           (redir_when == 3 && bus.i_mem_res_valid && bus.o_mem_res_ready);
    if (fire) begin
      bus.i_redirect = 1; bus.i_redirect_addr = redir_addr; redir_when = 0; redir_fired = 1;
    end
    #1;
    chk("res_ready_only_when_pending", bus.o_mem_res_ready && pend0 == 0, 0);
    if (bus.o_byte_valid && bus.i_byte_ready && !bus.i_redirect) begin
      chk("pop_byte", bus.o_byte, mem_byte(exp_addr));
`ifdef INSN_FETCH_BYTE_ADDR_EN
      chk("pop_byte_addr", bus.o_byte_addr, exp_addr);
      ba_q.push_back(bus.o_byte_addr);
`endif
      pop_q.push_back(32'(bus.o_byte));
      exp_addr++;
    end
    if (bus.i_mem_res_valid && bus.o_mem_res_ready) pend = 0;
    else if (pend > 0 && pend_dly > 0) pend_dly--;
    if (bus.o_mem_valid && bus.i_mem_ready) begin
      chk("one_outstanding", pend0, 0);
      chk("mem_cmd_read", bus.o_mem_cmd, 0);
      chk("mem_wdata_zero", bus.o_mem_data, 0);
      chk("addr_aligned", bus.o_mem_address[1:0], 0);
      req_q.push_back(bus.o_mem_address);
      pend = 1; pend_addr = bus.o_mem_address;
      pend_dly = $urandom_range(lat_max, lat_min);
    end
    if (bus.i_redirect) begin
      exp_addr = bus.i_redirect_addr; post_redir = 1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_req = 1;
    repeat (n) step();
    rst_req = 0;
  endtask

  task automatic arm_redirect(input int mode, input logic [31:0] a);
    redir_when = mode; redir_addr = a; redir_fired = 0;
    for (int i = 0; i < 40 && !redir_fired; i++) step();
    chk("redirect_fired", redir_fired, 1);
    redir_when = 0;
    req_q.delete(); pop_q.delete(); ba_q.delete();
  endtask

  initial begin
    bus.i_mem_ready = 0; bus.i_mem_res_valid = 0; bus.i_byte_ready = 0;
    bus.i_redirect = 0; bus.i_mem_data = '0; bus.i_redirect_addr = '0;
    tbl[0] = '{32'h102,      32'h100,      8'hCC, 8'hDD};
    tbl[1] = '{32'h000,      32'h000,      8'h01, 8'h02};
    tbl[2] = '{32'h007,      32'h004,      8'h08, 8'h09};
    tbl[3] = '{32'h203,      32'h200,      8'h06, 8'h07};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 8'hFF, 8'h01};

    // reset, first fetch, latency and little-endian order
    do_reset(3);
    p_ready = 100; p_bready = 100; lat_min = 0; lat_max = 0;
    step();
    chk("first_valid_after_reset", req_q.size(), 1);
    chk("first_addr", qat(req_q, 0), 32'h0);
    step();
    chk("byte_valid_before_push", bus.o_byte_valid, 0);
    step();
    chk("byte_valid_after_push", bus.o_byte_valid, 1);
    repeat (20) step();
    chk("second_addr", qat(req_q, 1), 32'h4);
    for (int i = 0; i < 8; i++) chk("seq_byte", qat(pop_q, i), 64'(i + 1));

    // FIFO fills: four requests, one pop is not enough, four pops re-enable
    do_reset(2);
    p_bready = 0;
    repeat (40) step();
    chk("full_req_count", req_q.size(), 4);
    chk("full_no_valid", bus.o_mem_valid, 0);
    p_bready = 100; step(); p_bready = 0;
    repeat (10) step();
    chk("one_pop_req_count", req_q.size(), 4);
    chk("one_pop_no_valid", bus.o_mem_valid, 0);
    p_bready = 100; repeat (3) step(); p_bready = 0;
    repeat (10) step();
    chk("four_pop_req_count", req_q.size(), 5);
    chk("four_pop_addr", qat(req_q, 4), 32'h10);

    // redirect table, including unaligned targets and address wrap
    p_bready = 100;
    foreach (tbl[i]) begin
      arm_redirect(1, tbl[i].addr);
      repeat (20) step();
      chk("tbl_req_addr", qat(req_q, 0), tbl[i].req);
      chk("tbl_byte0", qat(pop_q, 0), tbl[i].b0);
      chk("tbl_byte1", qat(pop_q, 1), tbl[i].b1);
`ifdef INSN_FETCH_BYTE_ADDR_EN
      chk("tbl_baddr0", qat(ba_q, 0), tbl[i].addr);
      chk("tbl_baddr1", qat(ba_q, 1), tbl[i].addr + 32'd1);
`endif
    end

    // redirect while waiting on the response for 0x8
    do_reset(2);
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 60 && !(req_q.size() > 0 && req_q[req_q.size()-1] == 32'h8); i++) step();
    chk("reached_wait_0x8", qat(req_q, req_q.size() - 1), 32'h8);
    arm_redirect(1, 32'h200);
    repeat (30) step();
    chk("wait_redir_req", qat(req_q, 0), 32'h200);
    chk("wait_redir_byte", qat(pop_q, 0), 8'h03);

    // redirect coinciding with request acceptance, then with a response
    lat_min = 1; lat_max = 2;
    arm_redirect(2, 32'h300);
    repeat (30) step();
    chk("acc_redir_req", qat(req_q, 0), 32'h300);
    chk("acc_redir_byte", qat(pop_q, 0), 8'h02);
    arm_redirect(3, 32'h341);
    repeat (30) step();
    chk("res_redir_req", qat(req_q, 0), 32'h340);
    chk("res_redir_byte", qat(pop_q, 0), 8'h41);

    // reset in the middle of a wait
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 20 && pend == 0; i++) step();
    chk("pending_before_reset", pend, 1);
    do_reset(2);
    lat_min = 0; lat_max = 2;
    step();
    chk("post_reset_addr", qat(req_q, 0), RESET_PC);
    chk("post_reset_empty", bus.o_byte_valid, 0);
    repeat (30) step();
    chk("post_reset_byte", qat(pop_q, 0), 8'h01);

    // randomized traffic with random redirects
    p_ready = 70; p_bready = 50; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (redir_when == 0 && $urandom_range(39) == 0) begin
        redir_when = $urandom_range(3, 1);
        redir_addr = ($urandom_range(9) == 0) ? 32'hFFFFFFF8 + $urandom_range(7)
                                              : 32'($urandom_range(32'h7FF));
      end
      step();
    end
    redir_when = 0;
    p_bready = 100;
    repeat (40) step();
    chk("drained_stream_nonempty", pop_q.size() > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
